// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//
// Shares one external combinational 2-bit adder ({cout,s1,s0} = a + b) between
// two requesters. A request is granted round-robin, its operands are driven
// onto dp_* and held for SETTLE cycles, then the adder result is captured and
// returned on a valid/ready response channel tagged with the requester id.
//
// Optional feature: define ADDSUB_ARB_STATS_EN to add the saturating per-
// requester grant counters grant_cnt0/grant_cnt1 (CNT_W bits each).
//
// Parameters
//   SETTLE  cycles operands are held on dp_* before capture (1..15)
//   CNT_W   grant counter width (only meaningful with ADDSUB_ARB_STATS_EN)
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req0_* / req1_*         request channels: valid, a[1:0], b[1:0], ready
//   rsp_valid/id/data/ready response channel, data = {cout,s1,s0}
//   dp_a1,dp_a0,dp_b1,dp_b0 operand bits to the adder
//   dp_cout,dp_s1,dp_s0     adder result bits
//   busy                    high whenever a transaction is in flight
//   grant_cnt0/grant_cnt1   accept counters (ADDSUB_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module addsub_arbiter #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [1:0] req0_a,
  input  logic [1:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_a,
  input  logic [1:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [2:0] rsp_data,
  input  logic       rsp_ready,
  output logic       dp_a1,
  output logic       dp_a0,
  output logic       dp_b1,
  output logic       dp_b0,
  input  logic       dp_cout,
  input  logic       dp_s1,
  input  logic       dp_s0,
  output logic       busy
`ifdef ADDSUB_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Settle counter value in the cycle the result is captured.
  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
    $error("addsub_arbiter: SETTLE must be within 1..15");
  end
  if (CNT_W < 1) begin : g_cnt_w_range
    $error("addsub_arbiter: CNT_W must be at least 1");
  end

  logic [1:0] r_state;
  logic       r_last_grant;
  logic [3:0] r_cnt;
  logic [1:0] r_a;
  logic [1:0] r_b;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [2:0] r_rsp_data;

  logic       w_idle;
  logic       w_sel;
  logic       w_accept;
  logic [1:0] w_a;
  logic [1:0] w_b;

  // Round-robin select: a lone requester wins outright; on a tie the
  // requester that did not win last time is chosen.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end
  end

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && !w_sel && req0_valid;
  assign req1_ready = w_idle &&  w_sel && req1_valid;
  assign w_a        = w_sel ? req1_a : req0_a;
  assign w_b        = w_sel ? req1_b : req0_b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;   // makes requester 0 win the first tie
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a          <= w_a;
            r_b          <= w_b;
            r_rsp_id     <= w_sel;
            r_last_grant <= w_sel;
            r_cnt        <= '0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LP_CNT_LAST) begin
            r_rsp_data  <= {dp_cout, dp_s1, dp_s0};
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operands stay on the adder after the response; only reset clears them.
  assign dp_a1     = r_a[1];
  assign dp_a0     = r_a[0];
  assign dp_b1     = r_b[1];
  assign dp_b0     = r_b[0];
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = !w_idle;

`ifdef ADDSUB_ARB_STATS_EN
  logic [CNT_W-1:0] r_grant_cnt0;
  logic [CNT_W-1:0] r_grant_cnt1;

  // Saturating accept counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (r_grant_cnt0 != '1)) begin
        r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
      end
      if (req1_ready && (r_grant_cnt1 != '1)) begin
        r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_addsub_arbiter
//
// Main instance (SETTLE=1) is checked every negedge against a transaction-level
// model: one op in flight, its accept cycle, the last winner, and a + b.
// Directed sequences pin the model with hand-computed values; a second
// instance (SETTLE=4) pins the longer latency. Randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_addsub_arbiter;

  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 4;
`ifdef ADDSUB_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- main instance ----------------
  logic       req0_valid, req1_valid, rsp_ready;
  logic [1:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [2:0] rsp_data;
  logic       dp_a1, dp_a0, dp_b1, dp_b0, dp_cout, dp_s1, dp_s0;
  logic [2:0] w_sum;
`ifdef ADDSUB_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  // Behavioural adder attached to the datapath port.
  assign w_sum = {1'b0, dp_a1, dp_a0} + {1'b0, dp_b1, dp_b0};
  assign {dp_cout, dp_s1, dp_s0} = w_sum;

  addsub_arbiter #(.SETTLE(SETTLE_A), .CNT_W(CW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .dp_a1(dp_a1), .dp_a0(dp_a0), .dp_b1(dp_b1), .dp_b0(dp_b0),
    .dp_cout(dp_cout), .dp_s1(dp_s1), .dp_s0(dp_s0),
    .busy(busy)
`ifdef ADDSUB_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // ---------------- second instance, SETTLE=4 ----------------
  logic       b_req0_valid, b_req1_valid, b_rsp_ready;
  logic [1:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
  logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_busy;
  logic [2:0] b_rsp_data;
  logic       b_dp_a1, b_dp_a0, b_dp_b1, b_dp_b0, b_dp_cout, b_dp_s1, b_dp_s0;
  logic [2:0] b_sum;
`ifdef ADDSUB_ARB_STATS_EN
  logic [CW-1:0] b_grant_cnt0, b_grant_cnt1;
`endif

  assign b_sum = {1'b0, b_dp_a1, b_dp_a0} + {1'b0, b_dp_b1, b_dp_b0};
  assign {b_dp_cout, b_dp_s1, b_dp_s0} = b_sum;

  addsub_arbiter #(.SETTLE(SETTLE_B), .CNT_W(CW)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(b_req0_valid), .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_ready(b_req1_ready),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_ready(b_rsp_ready),
    .dp_a1(b_dp_a1), .dp_a0(b_dp_a0), .dp_b1(b_dp_b1), .dp_b0(b_dp_b0),
    .dp_cout(b_dp_cout), .dp_s1(b_dp_s1), .dp_s0(b_dp_s0),
    .busy(b_busy)
`ifdef ADDSUB_ARB_STATS_EN
    , .grant_cnt0(b_grant_cnt0), .grant_cnt1(b_grant_cnt1)
`endif
  );

  // ---------------- transaction-level model of the main instance ----------------
  bit m_op = 1'b0;   // a transaction is in flight
  int m_id = 0, m_a = 0, m_b = 0, m_acc = 0, m_last = 1;
  int m_dpa = 0, m_dpb = 0, m_c0 = 0, m_c1 = 0;
  int cyc = 0;

  always @(negedge clk) begin
    int sel, exp_r0, exp_r1, exp_rv;
    if (!reset_n) begin
      m_op = 1'b0; m_last = 1; m_dpa = 0; m_dpb = 0; m_c0 = 0; m_c1 = 0;
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
    end
    exp_rv = (m_op && cyc >= m_acc + SETTLE_A + 1) ? 1 : 0;
    if (req0_valid && req1_valid) sel = 1 - m_last;
    else sel = req1_valid ? 1 : 0;
    exp_r0 = (!m_op && req0_valid && sel == 0) ? 1 : 0;
    exp_r1 = (!m_op && req1_valid && sel == 1) ? 1 : 0;
    check("m_req0_ready", req0_ready, exp_r0);
    check("m_req1_ready", req1_ready, exp_r1);
    check("m_busy", busy, m_op ? 1 : 0);
    check("m_rsp_valid", rsp_valid, exp_rv);
    check("m_dp_a", {dp_a1, dp_a0}, m_dpa);
    check("m_dp_b", {dp_b1, dp_b0}, m_dpb);
    if (exp_rv == 1) begin
      check("m_rsp_data", rsp_data, m_a + m_b);
      check("m_rsp_id", rsp_id, m_id);
    end
`ifdef ADDSUB_ARB_STATS_EN
    check("m_grant_cnt0", grant_cnt0, m_c0);
    check("m_grant_cnt1", grant_cnt1, m_c1);
`endif
    if (reset_n) begin
      if (!m_op) begin
        if (req0_valid || req1_valid) begin
          m_op   = 1'b1;
          m_id   = sel;
          m_a    = (sel == 1) ? int'(req1_a) : int'(req0_a);
          m_b    = (sel == 1) ? int'(req1_b) : int'(req0_b);
          m_dpa  = m_a;
          m_dpb  = m_b;
          m_acc  = cyc;
          m_last = sel;
          if (sel == 0) m_c0 = (m_c0 < (1 << CW) - 1) ? m_c0 + 1 : m_c0;
          else          m_c1 = (m_c1 < (1 << CW) - 1) ? m_c1 + 1 : m_c1;
        end
      end else if (exp_rv == 1 && rsp_ready) begin
        m_op = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int g[4];
  int ng;
  int rd[4];
  int ri[4];
  int nr;
  bit seen;

  initial begin
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    b_req0_valid = 0; b_req1_valid = 0; b_rsp_ready = 1;
    b_req0_a = 0; b_req0_b = 0; b_req1_a = 0; b_req1_b = 0;

    repeat (2) @(posedge clk);
    #1 check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    reset_n = 1;

    // Test 1: single op, SETTLE=1, 3+2
    req0_valid = 1; req0_a = 2'd3; req0_b = 2'd2;
    #1 check("t1_ready_T", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    #1 check("t1_rsp_valid_T1", rsp_valid, 0);
    check("t1_busy_T1", busy, 1);
    @(posedge clk); #2;
    check("t1_rsp_valid_T2", rsp_valid, 1);
    check("t1_rsp_data", rsp_data, 3'b101);
    check("t1_rsp_id", rsp_id, 0);
    @(posedge clk); #2;
    check("t1_busy_T3", busy, 0);
    check("t1_rsp_valid_T3", rsp_valid, 0);

    // Test 2: both requesters held valid after reset -> alternate grants
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
    req0_valid = 1; req0_a = 2'd1; req0_b = 2'd1;
    req1_valid = 1; req1_a = 2'd2; req1_b = 2'd3;
    ng = 0; nr = 0;
    for (int i = 0; i < 4; i++) begin g[i] = -1; rd[i] = -1; ri[i] = -1; end
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready && ng < 4) begin g[ng] = 0; ng++; end
      if (req1_ready && ng < 4) begin g[ng] = 1; ng++; end
      if (rsp_valid && nr < 4) begin rd[nr] = int'(rsp_data); ri[nr] = int'(rsp_id); nr++; end
      @(posedge clk); #1;
    end
    check("t2_grant0", g[0], 0);
    check("t2_grant1", g[1], 1);
    check("t2_grant2", g[2], 0);
    check("t2_grant3", g[3], 1);
    check("t2_rsp0_data", rd[0], 3'b010);
    check("t2_rsp0_id", ri[0], 0);
    check("t2_rsp1_data", rd[1], 3'b101);
    check("t2_rsp1_id", ri[1], 1);

    // Test 3: response back-pressure; req0 wins (last grant was req1)
    rsp_ready = 0;
    req0_a = 2'd2; req0_b = 2'd1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #2;
      if (rsp_valid) seen = 1;
    end
    check("t3_wait_rsp", seen, 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_rsp_valid", rsp_valid, 1);
      check("t3_rsp_data", rsp_data, 3'b011);
      check("t3_rsp_id", rsp_id, 0);
      check("t3_busy", busy, 1);
      check("t3_req0_ready", req0_ready, 0);
      check("t3_req1_ready", req1_ready, 0);
      @(posedge clk); #2;
    end
    rsp_ready = 1; req0_valid = 0; req1_valid = 0;
    @(posedge clk); #2;
    check("t3_rsp_valid_after", rsp_valid, 0);
    check("t3_busy_after", busy, 0);

    // Test 4: reset in SETTLE discards the transaction
    req1_valid = 1; req1_a = 2'd1; req1_b = 2'd0;
    @(posedge clk); #1 req1_valid = 0; reset_n = 0;
    #1;
    check("t4_rst_rsp_valid", rsp_valid, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_rsp_data", rsp_data, 0);
    check("t4_rst_rsp_id", rsp_id, 0);
    check("t4_rst_dp", {dp_a1, dp_a0, dp_b1, dp_b0}, 0);
    check("t4_rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1 reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t4_no_rsp", rsp_valid, 0);
    end
    req1_valid = 1; req1_a = 2'd3; req1_b = 2'd3;
    #1 check("t4_req1_ready", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    @(posedge clk); #1;
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_data", rsp_data, 3'b110);
    check("t4_rsp_id", rsp_id, 1);

    // Test 5: SETTLE=4 instance, response exactly T+5
    @(posedge clk); #1;
    b_req1_valid = 1; b_req1_a = 2'd2; b_req1_b = 2'd1;
    #1 check("t5_req1_ready", b_req1_ready, 1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) b_req1_valid = 0;
      check("t5_rsp_valid", b_rsp_valid, (k == 5) ? 1 : 0);
      if (k == 5) begin
        check("t5_rsp_data", b_rsp_data, 3'b011);
        check("t5_rsp_id", b_rsp_id, 1);
      end
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = 2'($urandom_range(0, 3)); req0_b = 2'($urandom_range(0, 3));
      req1_a = 2'($urandom_range(0, 3)); req1_b = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) @(posedge clk);

`ifdef ADDSUB_ARB_STATS_EN
    // Test 6: counter saturation with CNT_W=2
    #1 reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
    for (int n = 0; n < 5; n++) begin
      req0_valid = 1; req0_a = 2'($urandom_range(0, 3)); req0_b = 2'($urandom_range(0, 3));
      #1 check("t6_req0_ready", req0_ready, 1);
      @(posedge clk); #1 req0_valid = 0;
      repeat (2) @(posedge clk);
      #1;
    end
    check("t6_grant_cnt0", grant_cnt0, 3);
    check("t6_grant_cnt1", grant_cnt1, 0);
`endif

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
